// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter that sequences two valid/ready producers onto one shared
// 2:1 mux. The grant is held across a burst, and rotation is forced after MAX_BURST
// beats, but only while the other channel is waiting.
module mux2_rr_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam logic [7:0] MaxCnt = 8'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e     state_q;
    logic       ptr_q;    // channel that wins the next tie
    logic       sel_q;
    logic [7:0] cnt_q;    // beats accepted in the current grant, saturating

    logic       cur_ch;
    logic       cur_req;
    logic       cur_last;
    logic       oth_req;
    logic       xfer;
    logic [7:0] cnt_inc;
    logic       rel;

    // Decode the active channel and the release conditions for the current grant.
    always_comb begin
        cur_ch    = (state_q == StGnt1);
        cur_req   = cur_ch ? req1 : req0;
        cur_last  = cur_ch ? last1 : last0;
        oth_req   = cur_ch ? req0 : req1;
        out_valid = ((state_q == StGnt0) & req0) | ((state_q == StGnt1) & req1);
        xfer      = out_valid & out_ready;
        cnt_inc   = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + 8'd1;
        // Withdrawal, a last beat, or a full burst with the other side waiting.
        rel       = !cur_req
                  | (xfer & cur_last)
                  | (xfer & (cnt_inc == MaxCnt) & oth_req);
    end

    // Grant FSM with its registered select, priority pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 && (!req1 || !ptr_q)) begin
                        state_q <= StGnt0;
                        sel_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                    end else if (req1) begin
                        state_q <= StGnt1;
                        sel_q   <= 1'b1;
                        cnt_q   <= 8'd0;
                    end
                end
                StGnt0, StGnt1: begin
                    if (rel) begin
                        ptr_q <= ~cur_ch;
                        cnt_q <= 8'd0;
                        if (oth_req) begin
                            // Hand over directly, no idle cycle in between.
                            state_q <= cur_ch ? StGnt0 : StGnt1;
                            sel_q   <= ~cur_ch;
                        end else if (!cur_req) begin
                            state_q <= StIdle;
                        end
                        // Otherwise re-grant the same channel with a fresh count.
                    end else if (xfer) begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The grants and the select come straight from registers; the data path is a plain mux.
    always_comb begin
        gnt0     = (state_q == StGnt0);
        gnt1     = (state_q == StGnt1);
        sel      = sel_q;
        out_data = sel_q ? data1 : data0;
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter with hand-computed expectations.
module tb_mux2_rr_arbiter;

    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1, last0, last1, out_ready;
    logic [DATA_W-1:0] data0, data1;
    logic              gnt0, gnt1, sel, out_valid;
    logic [DATA_W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .data0     (data0),
        .last0     (last0),
        .req1      (req1),
        .data1     (data1),
        .last1     (last1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; last0 = 1'b0; last1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; out_ready = 1'b0;

        // Reset with both channels requesting.
        repeat (3) tick();
        check_eq("rst_gnt0", gnt0, 0);
        check_eq("rst_gnt1", gnt1, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_sel", sel, 0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_gnt0", gnt0, 1);
        check_eq("post_rst_gnt1", gnt1, 0);
        check_eq("post_rst_valid", out_valid, 1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_eq("withdraw_idle", gnt0, 0);

        // Single-channel burst on channel 1.
        req1 = 1'b1; data1 = 8'h11; out_ready = 1'b1;
        tick();
        #1;
        check_eq("burst_sel", sel, 1);
        check_eq("burst_gnt1", gnt1, 1);
        check_eq("burst_d11", out_data, 8'h11);
        tick();
        data1 = 8'h22; #1;
        check_eq("burst_d22", out_data, 8'h22);
        tick();
        data1 = 8'h33; last1 = 1'b1; #1;
        check_eq("burst_d33", out_data, 8'h33);
        check_eq("burst_valid", out_valid, 1);
        tick();
        req1 = 1'b0; last1 = 1'b0; #1;
        check_eq("burst_done_valid", out_valid, 0);
        tick();
        check_eq("burst_idle_gnt1", gnt1, 0);
        check_eq("idle_sel_hold", sel, 1);

        // Round-robin tie with last on every beat.
        req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
        data0 = 8'hA0; data1 = 8'hB1;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2 == 1) ? 1 : 0);
            check_eq($sformatf("rr_data_%0d", i), out_data, (i % 2 == 0) ? 8'hA0 : 8'hB1);
            check_eq($sformatf("rr_valid_%0d", i), out_valid, 1);
            tick();
        end

        // Forced rotation: channel 0 streams without last while channel 1 waits.
        last0 = 1'b0; last1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rot_gnt0_%0d", i), gnt0, 1);
            tick();
        end
        check_eq("rot_gnt1", gnt1, 1);
        check_eq("rot_gnt0_off", gnt0, 0);

        // Backpressure mid-burst on channel 1; the counter must not advance while stalled.
        req0 = 1'b0; data1 = 8'h51; #1;
        check_eq("bp_d51", out_data, 8'h51);
        tick();
        out_ready = 1'b0; data1 = 8'h52;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("bp_valid_%0d", i), out_valid, 1);
            check_eq($sformatf("bp_gnt1_%0d", i), gnt1, 1);
            check_eq($sformatf("bp_data_%0d", i), out_data, 8'h52);
            tick();
        end
        // One beat already taken, so exactly three more before rotating to channel 0.
        out_ready = 1'b1; req0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("bp_resume_gnt1_%0d", i), gnt1, 1);
            tick();
        end
        check_eq("bp_rotate_gnt0", gnt0, 1);

        // Reset asserted between edges during GNT1.
        req0 = 1'b0;
        tick();
        check_eq("mid_gnt1", gnt1, 1);
        check_eq("mid_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_gnt1", gnt1, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_sel", sel, 0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("after_rst_gnt0", gnt0, 1);
        check_eq("after_rst_gnt1", gnt1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Sequencing controller for a shared 2:1 mux (inputs a/b, select c, output y).
- Arbitrates between two requester channels with round-robin fairness and holds the grant across a burst.
- Drives the mux select and presents a single valid/ready output stream.
- Sits in front of the shared datapath so that two producers can share one consumer.

Parameters:
- DATA_W, 8, width of each data channel and of out_data.
- MAX_BURST, 4, beats allowed per grant before a forced rotation while the other channel is requesting. Legal range is 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- req0  input  1  channel 0 request / data valid.
- data0  input  DATA_W  channel 0 data.
- last0  input  1  channel 0 final beat of burst.
- req1  input  1  channel 1 request / data valid.
- data1  input  DATA_W  channel 1 data.
- last1  input  1  channel 1 final beat of burst.
- gnt0  output  1  channel 0 granted; a beat is accepted when gnt0 & req0 & out_ready.
- gnt1  output  1  channel 1 granted; a beat is accepted when gnt1 & req1 & out_ready.
- sel  output  1  mux select to the shared 2:1 mux: 0 selects channel 0, 1 selects channel 1.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  selected data.
- out_ready  input  1  downstream ready.

Behaviour:
- Asynchronous reset is active low and takes effect immediately.
  - State goes to IDLE, with gnt0=0, gnt1=0, sel=0, out_valid=0.
  - Priority pointer is set to 0 (channel 0 wins the first tie).
  - Beat counter is set to 0.
- Reset asserted mid-burst drops the grant immediately. The beat is not transferred, and there is no partial handshake afterwards.
- FSM states are IDLE, GNT0, GNT1.
  - gnt0=1 only in GNT0; gnt1=1 only in GNT1. Both are registered (state-decoded) and are never both 1.
  - sel is registered: 0 in GNT0, 1 in GNT1, and holds its last value in IDLE.
- out_data equals data0 when sel=0 and data1 when sel=1. It is combinational from sel.
- out_valid is combinational: (GNT0 & req0) | (GNT1 & req1).
- A transfer (xfer) occurs on a cycle with out_valid & out_ready.
- IDLE transitions:
  - Only req0 set: next state is GNT0.
  - Only req1 set: next state is GNT1.
  - Both set: go to the channel named by the priority pointer.
  - Neither set: stay in IDLE.
  - Latency from request to grant is 1 cycle. No beat transfers in the IDLE cycle.
- Beat counter:
  - Cleared on grant entry.
  - Increments on each xfer.
  - Width is 8 bits and saturates at MAX_BURST.
- Release from GNTx occurs at the clock edge after any of these conditions:
  - (a) xfer with lastx=1.
  - (b) xfer that brings the count to MAX_BURST while the other req is 1.
  - (c) reqx=0 (requester withdrew).
- On release:
  - The priority pointer is set to the other channel.
  - If the other req is 1, go directly to the other GNT state (zero idle cycles).
  - If the other req is 0 but reqx is still 1 (case b cannot apply here), re-grant x with the counter cleared.
  - Otherwise go to IDLE.
- Without release, the state holds. out_ready=0 stalls the burst indefinitely: no timeout and no rotation.
- Burst rotation when the count reaches MAX_BURST and the other channel is idle:
  - The grant is kept and the counter is held saturated.
  - Rotation occurs after the next xfer once the other req rises.
- Data and last must be held stable by the requester while req=1 and the beat is not accepted. The arbiter does not check this.
- Simultaneous events:
  - A release condition and a rising request from the other channel on the same cycle: the switch takes effect next cycle.
  - lastx together with the MAX_BURST condition on the same xfer: treated as a single release.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles with req0=req1=1 -> gnt0=gnt1=0, out_valid=0, sel=0. Release reset -> gnt0=1 one cycle later.
- Single channel burst: req1=1, data1 sequence 0x11, 0x22, 0x33 with last1 on 0x33, out_ready=1 -> sel=1. out_data shows 0x11, 0x22, 0x33 on consecutive cycles, then IDLE.
- Round-robin tie: req0=req1=1 continuous, last on every beat -> grants alternate 0,1,0,1. Each grant transfers exactly 1 beat with no idle gap.
- Forced rotation: MAX_BURST=4, req0 streaming with no last, req1=1 -> channel 0 transfers exactly 4 beats, then gnt1=1 on the next cycle.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> out_valid=1, the grant is held, out_data is stable, and the beat counter is unchanged.
- Reset mid-burst: assert rst_n=0 asynchronously between edges during GNT1 -> gnt1 and out_valid go to 0 immediately. After reset, channel 0 wins the tie.
